jt12_wrdec: RTL and testbench

//  CPU write decoder directly upstream of the operator/channel register file.

---
 rtl/jt12_wrdec_if.sv | 23 ++
 rtl/jt12_wrdec.sv | 118 +++++++++++
 tb/tb_jt12_wrdec.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_wrdec_if.sv
// jt12_wrdec_if: CPU write port and register-file strobe/handshake bundle for jt12_wrdec.
interface jt12_wrdec_if;
   logic [7:0] cpu_din;
   logic [1:0] cpu_addr;
   logic       cpu_wr;
   logic       busy_in;
   logic       busy_out;
   logic [7:0] din;
   logic [2:0] ch;
   logic [1:0] op;
   logic       up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1;
   logic       up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg;
   modport master (
      output cpu_din, cpu_addr, cpu_wr, busy_in,
      input  busy_out, din, ch, op, up_keyon, up_alg, up_block, up_fnumlo, up_pms,
             up_dt1, up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg
   );
   modport slave (
      input  cpu_din, cpu_addr, cpu_wr, busy_in,
      output busy_out, din, ch, op, up_keyon, up_alg, up_block, up_fnumlo, up_pms,
             up_dt1, up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg
   );
endinterface

// File: rtl/jt12_wrdec.sv
// jt12_wrdec: YM2612 bus write decoder with held update strobes, mode register and CH3 fnum/block.
// Define JT12_CH3_EFFECT_EN to enable the CH3 per-operator frequency registers and the effect output.
module jt12_wrdec (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   jt12_wrdec_if.slave bus,
   output logic        effect,
   output logic        csm,
   output logic [10:0] fnum_ch3op1,
   output logic [10:0] fnum_ch3op2,
   output logic [10:0] fnum_ch3op3,
   output logic [2:0]  block_ch3op1,
   output logic [2:0]  block_ch3op2,
   output logic [2:0]  block_ch3op3
);
   typedef enum logic [1:0] {IDLE, STRB, HOLD} state_t;
   state_t      st, st_nx;
   logic [4:0]  cnt, cnt_nx;
   logic [8:0]  addr_lat;
   logic [11:0] upd, sel;
   logic [7:0]  rg, din_r;
   logic [2:0]  ch_r, ch_nx;
   logic [1:0]  op_r, mode;
   logic        part, addr_wr, data_wr, ch_ok, op_rng;
   assign rg      = addr_lat[7:0];
   assign part    = addr_lat[8];
   assign addr_wr = clk_en & bus.cpu_wr & ~bus.cpu_addr[0];
   assign data_wr = clk_en & bus.cpu_wr & bus.cpu_addr[0] & (st == IDLE);
   assign ch_ok   = rg[1:0] != 2'd3;
   assign op_rng  = rg >= 8'h30 && rg <= 8'h9F && ch_ok;
   assign ch_nx   = sel[11] ? bus.cpu_din[2:0] : {part, rg[1:0]};
   // sel bit order: keyon, alg, block, fnumlo, pms, dt1, tl, ks_ar, amen_d1r, d2r, d1l, ssgeg
   always_comb begin
      sel = 12'd0;
      if (data_wr) begin
         sel[11] = ~part && rg == 8'h28 && bus.cpu_din[1:0] != 2'd3;
         sel[10] = rg[7:2] == 6'b101100 && ch_ok;
         sel[9]  = rg[7:2] == 6'b101001 && ch_ok;
         sel[8]  = rg[7:2] == 6'b101000 && ch_ok;
         sel[7]  = rg[7:2] == 6'b101101 && ch_ok;
         sel[6]  = op_rng && rg[7:4] == 4'h3;
         sel[5]  = op_rng && rg[7:4] == 4'h4;
         sel[4]  = op_rng && rg[7:4] == 4'h5;
         sel[3]  = op_rng && rg[7:4] == 4'h6;
         sel[2]  = op_rng && rg[7:4] == 4'h7;
         sel[1]  = op_rng && rg[7:4] == 4'h8;
         sel[0]  = op_rng && rg[7:4] == 4'h9;
      end
   end
   // STRB gives up after 31 enables without busy_in so a missing register file cannot lock the bus
   always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      if (clk_en) begin
         st_nx  = st == IDLE ? (|sel ? STRB : IDLE) :
                  st == STRB ? (bus.busy_in ? HOLD : cnt == 5'd30 ? IDLE : STRB) :
                               (bus.busy_in ? HOLD : IDLE);
         cnt_nx = st == STRB ? cnt + 5'd1 : 5'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         cnt      <= 5'd0;
         addr_lat <= 9'd0;
         upd      <= 12'd0;
         din_r    <= 8'd0;
         ch_r     <= 3'd0;
         op_r     <= 2'd0;
         mode     <= 2'd0;
      end else begin
         st  <= st_nx;
         cnt <= cnt_nx;
         if (addr_wr) addr_lat <= {bus.cpu_addr[1], bus.cpu_din};
         if (|sel) begin
            upd   <= sel;
            din_r <= bus.cpu_din;
            ch_r  <= ch_nx;
            op_r  <= rg[3:2];
         end else if (st_nx == IDLE) upd <= 12'd0;
         if (data_wr && !part && rg == 8'h27) mode <= bus.cpu_din[7:6];
      end
   end
   assign bus.busy_out = st != IDLE;
   assign bus.din      = din_r;
   assign bus.ch       = ch_r;
   assign bus.op       = op_r;
   assign {bus.up_keyon, bus.up_alg, bus.up_block, bus.up_fnumlo, bus.up_pms, bus.up_dt1,
           bus.up_tl, bus.up_ks_ar, bus.up_amen_d1r, bus.up_d2r, bus.up_d1l, bus.up_ssgeg} = upd;
   assign csm = mode == 2'b10;
`ifdef JT12_CH3_EFFECT_EN
   logic [5:0] ch3_lat;
   assign effect = |mode;
   // ch3_lat holds {block, fnum[10:8]} until the matching low byte arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         ch3_lat <= 6'd0;
         {block_ch3op1, fnum_ch3op1} <= 14'd0;
         {block_ch3op2, fnum_ch3op2} <= 14'd0;
         {block_ch3op3, fnum_ch3op3} <= 14'd0;
      end else if (data_wr && !part) begin
         if (rg >= 8'hAC && rg <= 8'hAE) ch3_lat <= bus.cpu_din[5:0];
         if (rg == 8'hA9) {block_ch3op1, fnum_ch3op1} <= {ch3_lat, bus.cpu_din};
         if (rg == 8'hAA) {block_ch3op2, fnum_ch3op2} <= {ch3_lat, bus.cpu_din};
         if (rg == 8'hA8) {block_ch3op3, fnum_ch3op3} <= {ch3_lat, bus.cpu_din};
      end
   end
`else
   assign effect       = 1'b0;
   assign fnum_ch3op1  = 11'd0;
   assign fnum_ch3op2  = 11'd0;
   assign fnum_ch3op3  = 11'd0;
   assign block_ch3op1 = 3'd0;
   assign block_ch3op2 = 3'd0;
   assign block_ch3op3 = 3'd0;
`endif
endmodule

// File: tb/tb_jt12_wrdec.sv
// tb_jt12_wrdec: scoreboard bench for jt12_wrdec; expected strobe/din/ch/op queued at each data write.
module tb_jt12_wrdec;
   localparam logic [11:0] KEYON = 12'h800, ALG = 12'h400, BLOCK = 12'h200, FNUMLO = 12'h100,
                           PMS = 12'h080, DT1 = 12'h040, TL = 12'h020, KSAR = 12'h010,
                           AMEN = 12'h008, D2R = 12'h004, D1L = 12'h002, SSGEG = 12'h001;
`ifdef JT12_CH3_EFFECT_EN
   localparam logic CH3 = 1'b1;
`else
   localparam logic CH3 = 1'b0;
`endif
   typedef struct packed {logic [11:0] up; logic [7:0] din; logic [2:0] ch; logic [1:0] op;} exp_t;
   typedef struct packed {logic p; logic [7:0] rg; logic [7:0] d; exp_t x;} vec_t;
   typedef struct packed {logic p; logic [7:0] rg; logic [7:0] d;} ign_t;
   logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
   logic        effect, csm;
   logic [10:0] f1, f2, f3;
   logic [2:0]  b1, b2, b3;
   logic [11:0] up_vec;
   int          vectors = 0, miscompares = 0;
   exp_t        sb[$];
   exp_t        e;
   jt12_wrdec_if bus();
   jt12_wrdec dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus), .effect(effect), .csm(csm),
      .fnum_ch3op1(f1), .fnum_ch3op2(f2), .fnum_ch3op3(f3),
      .block_ch3op1(b1), .block_ch3op2(b2), .block_ch3op3(b3)
   );
   always #5 clk = ~clk;
   assign up_vec = {bus.up_keyon, bus.up_alg, bus.up_block, bus.up_fnumlo, bus.up_pms, bus.up_dt1,
                    bus.up_tl, bus.up_ks_ar, bus.up_amen_d1r, bus.up_d2r, bus.up_d1l, bus.up_ssgeg};

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic a1, input logic a0, input logic [7:0] d);
      bus.cpu_addr = {a1, a0};
      bus.cpu_din  = d;
      bus.cpu_wr   = 1'b1;
      tick();
      bus.cpu_wr   = 1'b0;
   endtask

   task automatic handshake;
      bus.busy_in = 1'b1;
      tick();
      bus.busy_in = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      tick(2);
      vectors++;
      if (up_vec !== 12'd0 || bus.busy_out !== 1'b0 || bus.din !== 8'd0 || bus.ch !== 3'd0 ||
          bus.op !== 2'd0 || effect !== 1'b0 || csm !== 1'b0 || f1 !== 11'd0 || b1 !== 3'd0) begin
         miscompares++;
         $display("FAIL reset: up=%h busy=%b din=%h ch=%0d op=%0d eff=%b csm=%b, want all 0",
                  up_vec, bus.busy_out, bus.din, bus.ch, bus.op, effect, csm);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_tl_hold;
      wr(1'b0, 1'b0, 8'h4D);
      sb.push_back({TL, 8'h7F, 3'd1, 2'd3});
      wr(1'b0, 1'b1, 8'h7F);
      e = sb.pop_front();
      vectors++;
      if (bus.busy_out !== 1'b1 || {up_vec, bus.din, bus.ch, bus.op} !== e) begin
         miscompares++;
         $display("FAIL tl_strobe: up=%h din=%h ch=%0d op=%0d busy=%b, want up=%h din=%h ch=%0d op=%0d busy=1",
                  up_vec, bus.din, bus.ch, bus.op, bus.busy_out, e.up, e.din, e.ch, e.op);
      end
      tick(3);
      vectors++;
      if (up_vec !== TL || bus.busy_out !== 1'b1) begin
         miscompares++;
         $display("FAIL tl_strb_hold: up=%h busy=%b, want up=%h busy=1", up_vec, bus.busy_out, TL);
      end
      bus.busy_in = 1'b1;
      tick(2);
      vectors++;
      if (up_vec !== TL || bus.busy_out !== 1'b1 || bus.din !== 8'h7F) begin
         miscompares++;
         $display("FAIL tl_busy_hold: up=%h busy=%b din=%h, want up=%h busy=1 din=7f", up_vec, bus.busy_out, bus.din, TL);
      end
      bus.busy_in = 1'b0;
      tick();
      vectors++;
      if (up_vec !== 12'd0 || bus.busy_out !== 1'b0 || bus.din !== 8'h7F) begin
         miscompares++;
         $display("FAIL tl_release: up=%h busy=%b din=%h, want up=0 busy=0 din=7f", up_vec, bus.busy_out, bus.din);
      end
   endtask

   task automatic test_decode;
      vec_t t[11] = '{
         {1'b1, 8'h3A, 8'h15, DT1,    8'h15, 3'd6, 2'd2},
         {1'b0, 8'h51, 8'h1F, KSAR,   8'h1F, 3'd1, 2'd0},
         {1'b1, 8'h6C, 8'h80, AMEN,   8'h80, 3'd4, 2'd3},
         {1'b0, 8'h75, 8'h0A, D2R,    8'h0A, 3'd1, 2'd1},
         {1'b1, 8'h8E, 8'hF3, D1L,    8'hF3, 3'd6, 2'd3},
         {1'b0, 8'h98, 8'h08, SSGEG,  8'h08, 3'd0, 2'd2},
         {1'b0, 8'hB1, 8'h07, ALG,    8'h07, 3'd1, 2'd0},
         {1'b1, 8'hB4, 8'hC0, PMS,    8'hC0, 3'd4, 2'd1},
         {1'b0, 8'hA0, 8'h55, FNUMLO, 8'h55, 3'd0, 2'd0},
         {1'b0, 8'h28, 8'hF5, KEYON,  8'hF5, 3'd5, 2'd2},
         {1'b0, 8'h28, 8'h06, KEYON,  8'h06, 3'd6, 2'd2}
      };
      foreach (t[i]) begin
         wr(t[i].p, 1'b0, t[i].rg);
         sb.push_back(t[i].x);
         wr(t[i].p, 1'b1, t[i].d);
         e = sb.pop_front();
         vectors++;
         if (bus.busy_out !== 1'b1 || {up_vec, bus.din, bus.ch, bus.op} !== e) begin
            miscompares++;
            $display("FAIL decode_%h: up=%h din=%h ch=%0d op=%0d busy=%b, want up=%h din=%h ch=%0d op=%0d busy=1",
                     t[i].rg, up_vec, bus.din, bus.ch, bus.op, bus.busy_out, e.up, e.din, e.ch, e.op);
         end
         handshake();
      end
   endtask

   task automatic test_ignored;
      ign_t t[7] = '{
         {1'b0, 8'h4F, 8'h11}, {1'b0, 8'hA3, 8'h22}, {1'b0, 8'hB7, 8'h33}, {1'b0, 8'h2F, 8'h44},
         {1'b1, 8'h28, 8'h01}, {1'b0, 8'h28, 8'h03}, {1'b1, 8'h27, 8'h80}
      };
      foreach (t[i]) begin
         wr(t[i].p, 1'b0, t[i].rg);
         wr(t[i].p, 1'b1, t[i].d);
         vectors++;
         if (up_vec !== 12'd0 || bus.busy_out !== 1'b0 || csm !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_%0d_%h: up=%h busy=%b csm=%b, want all 0", t[i].p, t[i].rg, up_vec, bus.busy_out, csm);
         end
      end
   endtask

   task automatic test_drop_in_hold;
      wr(1'b1, 1'b0, 8'hA6);
      sb.push_back({BLOCK, 8'h22, 3'd6, 2'd1});
      wr(1'b1, 1'b1, 8'h22);
      e = sb.pop_front();
      vectors++;
      if (bus.busy_out !== 1'b1 || {up_vec, bus.din, bus.ch, bus.op} !== e) begin
         miscompares++;
         $display("FAIL block_strobe: up=%h din=%h ch=%0d op=%0d, want up=%h din=%h ch=%0d op=%0d",
                  up_vec, bus.din, bus.ch, bus.op, e.up, e.din, e.ch, e.op);
      end
      bus.busy_in = 1'b1;
      tick();
      wr(1'b1, 1'b1, 8'h99);
      vectors++;
      if (bus.din !== 8'h22 || up_vec !== BLOCK || bus.busy_out !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_in_hold: din=%h up=%h busy=%b, want din=22 up=%h busy=1", bus.din, up_vec, bus.busy_out, BLOCK);
      end
      bus.busy_in = 1'b0;
      tick();
      vectors++;
      if (bus.din !== 8'h22 || up_vec !== 12'd0 || bus.busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_release: din=%h up=%h busy=%b, want din=22 up=0 busy=0", bus.din, up_vec, bus.busy_out);
      end
   endtask

   task automatic test_mode;
      logic [7:0] d[3] = '{8'h80, 8'h40, 8'h00};
      logic       c[3] = '{1'b1, 1'b0, 1'b0};
      logic       f[3] = '{CH3, CH3, 1'b0};
      wr(1'b0, 1'b0, 8'h27);
      foreach (d[i]) begin
         wr(1'b0, 1'b1, d[i]);
         vectors++;
         if (csm !== c[i] || effect !== f[i] || bus.busy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_%h: csm=%b effect=%b busy=%b, want csm=%b effect=%b busy=0",
                     d[i], csm, effect, bus.busy_out, c[i], f[i]);
         end
      end
      wr(1'b0, 1'b0, 8'h4D);
      wr(1'b0, 1'b1, 8'h33);
      wr(1'b0, 1'b0, 8'h27);
      wr(1'b0, 1'b1, 8'h80);
      vectors++;
      if (csm !== 1'b0 || bus.busy_out !== 1'b1) begin
         miscompares++;
         $display("FAIL mode_drop_busy: csm=%b busy=%b, want csm=0 busy=1", csm, bus.busy_out);
      end
      handshake();
      wr(1'b0, 1'b1, 8'h80);
      vectors++;
      if (csm !== 1'b1 || bus.busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL mode_addr_in_busy: csm=%b busy=%b, want csm=1 busy=0", csm, bus.busy_out);
      end
      wr(1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_ch3;
      wr(1'b0, 1'b0, 8'hAD); wr(1'b0, 1'b1, 8'h2B);
      wr(1'b0, 1'b0, 8'hA9); wr(1'b0, 1'b1, 8'hCD);
      vectors++;
      if (b1 !== (CH3 ? 3'd5 : 3'd0) || f1 !== (CH3 ? 11'h3CD : 11'd0) || bus.busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL ch3_op1: block=%0d fnum=%h busy=%b, want block=%0d fnum=%h busy=0",
                  b1, f1, bus.busy_out, CH3 ? 5 : 0, CH3 ? 11'h3CD : 11'd0);
      end
      wr(1'b0, 1'b0, 8'hAC); wr(1'b0, 1'b1, 8'h3F);
      wr(1'b0, 1'b0, 8'hA8); wr(1'b0, 1'b1, 8'h01);
      wr(1'b0, 1'b0, 8'hAE); wr(1'b0, 1'b1, 8'h08);
      wr(1'b0, 1'b0, 8'hAA); wr(1'b0, 1'b1, 8'hFF);
      wr(1'b1, 1'b0, 8'hA9); wr(1'b1, 1'b1, 8'h00);
      vectors++;
      if ({b3, f3, b2, f2, b1, f1} !== (CH3 ? {3'd7, 11'h701, 3'd1, 11'h0FF, 3'd5, 11'h3CD} : 42'd0)) begin
         miscompares++;
         $display("FAIL ch3_ops: op3=%0d/%h op2=%0d/%h op1=%0d/%h, macro=%b", b3, f3, b2, f2, b1, f1, CH3);
      end
   endtask

   task automatic test_timeout;
      wr(1'b0, 1'b0, 8'h4D);
      sb.push_back({TL, 8'h11, 3'd1, 2'd3});
      wr(1'b0, 1'b1, 8'h11);
      e = sb.pop_front();
      vectors++;
      if (bus.busy_out !== 1'b1 || {up_vec, bus.din, bus.ch, bus.op} !== e) begin
         miscompares++;
         $display("FAIL timeout_strobe: up=%h din=%h busy=%b, want up=%h din=%h busy=1", up_vec, bus.din, bus.busy_out, e.up, e.din);
      end
      tick(30);
      vectors++;
      if (bus.busy_out !== 1'b1 || up_vec !== TL) begin
         miscompares++;
         $display("FAIL timeout_early: busy=%b up=%h after 30 enables, want busy=1 up=%h", bus.busy_out, up_vec, TL);
      end
      tick();
      vectors++;
      if (bus.busy_out !== 1'b0 || up_vec !== 12'd0) begin
         miscompares++;
         $display("FAIL timeout_expire: busy=%b up=%h after 31 enables, want 0/0", bus.busy_out, up_vec);
      end
   endtask

   task automatic test_back_to_back;
      sb.push_back({TL, 8'h01, 3'd1, 2'd3});
      sb.push_back({TL, 8'h02, 3'd1, 2'd3});
      for (int i = 1; i <= 2; i++) begin
         wr(1'b0, 1'b1, 8'(i));
         e = sb.pop_front();
         vectors++;
         if (bus.busy_out !== 1'b1 || {up_vec, bus.din, bus.ch, bus.op} !== e) begin
            miscompares++;
            $display("FAIL back_to_back_%0d: up=%h din=%h busy=%b, want up=%h din=%h busy=1", i, up_vec, bus.din, bus.busy_out, e.up, e.din);
         end
         handshake();
      end
   endtask

   task automatic test_rst_hold;
      wr(1'b0, 1'b1, 8'h22);
      bus.busy_in = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if (up_vec !== 12'd0 || bus.busy_out !== 1'b0 || bus.din !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_in_hold: up=%h busy=%b din=%h, want 0/0/00", up_vec, bus.busy_out, bus.din);
      end
      rst = 1'b0;
      bus.busy_in = 1'b0;
      wr(1'b0, 1'b1, 8'h5A);
      vectors++;
      if (bus.busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_addr_latch: busy=%b, want 0 (latch cleared to reg 00)", bus.busy_out);
      end
   endtask

   task automatic test_clk_en;
      clk_en = 1'b0;
      wr(1'b0, 1'b0, 8'h4D);
      clk_en = 1'b1;
      wr(1'b0, 1'b1, 8'h44);
      vectors++;
      if (bus.busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL clk_en_addr: busy=%b, want 0 (gated address write)", bus.busy_out);
      end
      wr(1'b0, 1'b0, 8'h4D);
      clk_en = 1'b0;
      wr(1'b0, 1'b1, 8'h44);
      vectors++;
      if (bus.busy_out !== 1'b0 || up_vec !== 12'd0) begin
         miscompares++;
         $display("FAIL clk_en_data: busy=%b up=%h, want 0/0", bus.busy_out, up_vec);
      end
      clk_en = 1'b1;
   endtask

   initial begin
      bus.cpu_din  = 8'd0;
      bus.cpu_addr = 2'd0;
      bus.cpu_wr   = 1'b0;
      bus.busy_in  = 1'b0;
      test_reset();
      test_tl_hold();
      test_decode();
      test_ignored();
      test_drop_in_hold();
      test_mode();
      test_ch3();
      test_timeout();
      test_back_to_back();
      test_rst_hold();
      test_clk_en();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
